// File: rtl/ib_slot_drain.sv
// Drains full RAM slots round-robin onto a 128-bit valid/ready stream.
// RdData returns one cycle after RdEn and lands in a 2-entry output buffer.
module ib_slot_drain #(
  parameter int SLOT_WORDS = 16,
  parameter int NSLOT      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSLOT-1:0]   DataValid,
  output logic [NSLOT-1:0]   RamValid,
  output logic               RdEn,
  output logic [31:0]        RdAddr,
  input  logic [127:0]       RdData,
  output logic [127:0]       out_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic               out_tlast,
  output logic [$clog2(NSLOT)-1:0] out_tslot,
  output logic [1:0]         fsm_state
);
  // Stream handshake: a beat moves on a rising edge where out_tvalid and
  // out_tready are both high; tdata/tlast/tslot hold while valid is stalled.

  localparam int CW  = $clog2(SLOT_WORDS) + 1;
  localparam int SLW = $clog2(NSLOT);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, RELEASE} state_t;

  state_t               state, state_n;
  logic [SLW-1:0]       slot, slot_n, last_slot, last_slot_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [NSLOT-1:0]     mask, mask_n, eligible;
  logic                 sel_found;
  logic [SLW-1:0]       sel_slot, cand;

  logic                 rd_pend, rd_last;
  logic [SLW-1:0]       rd_slot;
  logic [1:0][127:0]    fifo_data;
  logic [1:0]           fifo_last;
  logic [1:0][SLW-1:0]  fifo_slot;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt, room_used;
  logic                 pop, issue, issue_last;

  assign fsm_state  = state;
  assign out_tvalid = (fifo_cnt != 2'd0);
  assign out_tdata  = fifo_data[rd_ptr];
  assign out_tslot  = fifo_slot[rd_ptr];
  assign out_tlast  = out_tvalid & fifo_last[rd_ptr];
  assign pop        = out_tvalid & out_tready;

  // Occupancy is counted after this cycle's pop so a ready sink sees one beat per cycle.
  assign room_used  = fifo_cnt - {1'b0, pop} + {1'b0, rd_pend};
  assign issue      = (state == READ) && (room_used < 2'd2);
  assign issue_last = issue && (cnt == CW'(SLOT_WORDS - 1));
  assign RdEn       = issue;
  assign RdAddr     = 32'(slot) * 32'(SLOT_WORDS) + 32'(cnt);

  assign eligible = DataValid & ~mask;

  always_comb begin
    sel_found = 1'b0;
    sel_slot  = '0;
    cand      = '0;
    for (int k = 1; k <= NSLOT; k++) begin
      cand = last_slot + SLW'(k);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_slot  = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    slot_n      = slot;
    cnt_n       = cnt;
    last_slot_n = last_slot;
    mask_n      = mask;
    RamValid    = '0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          slot_n  = sel_slot;
          cnt_n   = '0;
          state_n = READ;
        end
      end
      READ: begin
        if (issue) begin
          cnt_n = cnt + CW'(1);
          if (issue_last) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && out_tlast) state_n = RELEASE;
      end
      RELEASE: begin
        RamValid[slot] = 1'b1;
        mask_n[slot]   = 1'b1;
        last_slot_n    = slot;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A slot becomes selectable again only once its writer has dropped DataValid.
    mask_n = mask_n & DataValid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      cnt       <= '0;
      last_slot <= SLW'(NSLOT - 1);
      mask      <= '0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      rd_slot   <= '0;
      fifo_data <= '0;
      fifo_last <= '0;
      fifo_slot <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      cnt       <= cnt_n;
      last_slot <= last_slot_n;
      mask      <= mask_n;
      rd_pend   <= issue;
      rd_last   <= issue_last;
      rd_slot   <= slot;
      if (rd_pend) begin
        fifo_data[wr_ptr] <= RdData;
        fifo_last[wr_ptr] <= rd_last;
        fifo_slot[wr_ptr] <= rd_slot;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_ib_slot_drain.sv
// Bench for ib_slot_drain: RAM model, beat scoreboard, vector table plus
// hand-written sequences for stall, reset abort and DataValid drop.
module tb_ib_slot_drain;
  localparam int SW = 16;
  localparam int BW = 132;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   DataValid;
  logic [7:0]   RamValid;
  logic         RdEn;
  logic [31:0]  RdAddr;
  logic [127:0] RdData = '0;
  logic [127:0] out_tdata;
  logic         out_tvalid;
  logic         out_tready;
  logic         out_tlast;
  logic [2:0]   out_tslot;
  logic [1:0]   fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int ready_mode = 0;
  logic [BW-1:0] exp_q[$];
  logic [7:0]    rv_q[$];
  logic [BW-1:0] prev_beat;
  bit            prev_stall = 1'b0;

  typedef struct {
    logic [7:0] dv;
    int         rmode;
    int         exp_slot;
  } vec_t;

  ib_slot_drain #(.SLOT_WORDS(SW)) dut (
    .clk(clk), .rst(rst), .DataValid(DataValid), .RamValid(RamValid),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_tslot(out_tslot), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] ram_word(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, 32'hC0DE_0000 + a};
  endfunction

  always @(posedge clk) RdData <= RdEn ? ram_word(RdAddr) : '0;

  // ready driver: 0 = always ready, 1 = random 50%, 2 = stalled
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_tready = 1'($urandom_range(0, 1));
        2:       out_tready = 1'b0;
        default: out_tready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_stable", {3'b0, out_tvalid, out_tslot, out_tlast, out_tdata}, {3'b0, 1'b1, prev_beat});
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: slot %0d data %h, no beat required", out_tslot, out_tdata);
        end else begin
          check("beat", {4'b0, out_tslot, out_tlast, out_tdata}, {4'b0, exp_q.pop_front()});
        end
      end
      if (RamValid != 8'h00) begin
        check("ramvalid_onehot", 136'($onehot(RamValid)), 136'(1));
        rv_q.push_back(RamValid);
      end
      if (RdEn) rd_cnt++;
      prev_stall = out_tvalid && !out_tready;
      prev_beat  = {out_tslot, out_tlast, out_tdata};
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_slot(input int s);
    for (int w = 0; w < SW; w++)
      exp_q.push_back({3'(s), (w == SW - 1), ram_word(32'(s * SW + w))});
  endtask

  task automatic wait_release(input string name, input logic [7:0] exp_rv, output int lat);
    lat = 0;
    while (rv_q.size() == 0 && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (rv_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no RamValid pulse within %0d cycles, required %h", name, lat, exp_rv);
    end else begin
      check(name, 136'(rv_q.pop_front()), 136'(exp_rv));
    end
    check({name, "_drained"}, 136'(exp_q.size()), 136'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tvalid"}, 136'(out_tvalid), 136'(0));
    check({name, "_tlast"}, 136'(out_tlast), 136'(0));
    check({name, "_tdata"}, 136'(out_tdata), 136'(0));
    check({name, "_tslot"}, 136'(out_tslot), 136'(0));
    check({name, "_rden"}, 136'(RdEn), 136'(0));
    check({name, "_rdaddr"}, 136'(RdAddr), 136'(0));
    check({name, "_ramvalid"}, 136'(RamValid), 136'(0));
    check({name, "_state"}, 136'(fsm_state), 136'(0));
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    int base;
    int t;

    vecs[0] = '{dv: 8'h09, rmode: 1, exp_slot: 3};
    vecs[1] = '{dv: 8'h09, rmode: 0, exp_slot: 0};
    vecs[2] = '{dv: 8'h80, rmode: 0, exp_slot: 7};
    vecs[3] = '{dv: 8'h81, rmode: 1, exp_slot: 0};
    vecs[4] = '{dv: 8'h42, rmode: 0, exp_slot: 1};
    vecs[5] = '{dv: 8'h42, rmode: 0, exp_slot: 6};
    vecs[6] = '{dv: 8'h24, rmode: 1, exp_slot: 2};
    vecs[7] = '{dv: 8'h24, rmode: 0, exp_slot: 5};

    rst = 1'b1;
    DataValid = 8'h00;
    cycles(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cycles(2);

    // full round robin with every slot pending: 0..7 then 0 again
    expect_slot(0);
    DataValid = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      wait_release($sformatf("rr_%0d", k), 8'(1 << (k % 8)), lat);
      if (k == 8) begin
        DataValid = 8'h00;
      end else begin
        expect_slot((k + 1) % 8);
        DataValid[k % 8] = 1'b0;
        cycles(2);
        DataValid[k % 8] = 1'b1;
      end
    end
    cycles(3);

    // single slot 0 at full rate, then no re-drain while DataValid stays high
    expect_slot(0);
    DataValid = 8'h01;
    wait_release("slot0", 8'h01, lat);
    check("slot0_latency_ok", 136'(lat >= 18 && lat <= 22), 136'(1));
    base = rd_cnt;
    cycles(30);
    check("slot0_no_redrain_reads", 136'(rd_cnt - base), 136'(0));
    check("slot0_no_redrain_pulse", 136'(rv_q.size()), 136'(0));
    DataValid = 8'h00;
    cycles(2);

    // vector table: priority from last_slot, random and steady ready
    for (int v = 0; v < 8; v++) begin
      ready_mode = vecs[v].rmode;
      expect_slot(vecs[v].exp_slot);
      DataValid = vecs[v].dv;
      wait_release($sformatf("vec%0d", v), 8'(1 << vecs[v].exp_slot), lat);
      DataValid = 8'h00;
      ready_mode = 0;
      cycles(3);
    end

    // long stall: only two reads may be outstanding
    ready_mode = 2;
    cycles(2);
    base = rd_cnt;
    expect_slot(2);
    DataValid = 8'h04;
    cycles(20);
    check("stall_reads", 136'(rd_cnt - base), 136'(2));
    check("stall_tvalid", 136'(out_tvalid), 136'(1));
    check("stall_head", {5'b0, out_tslot, out_tdata}, {5'b0, 3'd2, ram_word(32'd32)});
    ready_mode = 0;
    wait_release("stall_release", 8'h04, lat);
    DataValid = 8'h00;
    cycles(3);

    // DataValid dropped mid-drain: slot still completes and is released
    expect_slot(2);
    DataValid = 8'h04;
    cycles(6);
    DataValid = 8'h00;
    wait_release("dv_drop", 8'h04, lat);
    cycles(3);

    // reset at word 7 of slot 5 aborts without a release, then re-drains from word 0
    expect_slot(5);
    DataValid = 8'h20;
    t = 0;
    while (!(RdEn && RdAddr == 32'd87) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_reached_word7", 136'(RdEn && RdAddr == 32'd87), 136'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    cycles(2);
    check("abort_no_ramvalid", 136'(rv_q.size()), 136'(0));
    expect_slot(5);
    rst = 1'b0;
    t = 0;
    while (!RdEn && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("redrain_first_addr", 136'(RdAddr), 136'(80));
    wait_release("redrain", 8'h20, lat);
    DataValid = 8'h00;
    cycles(5);

    check("final_queue_empty", 136'(exp_q.size()), 136'(0));
    check("final_no_extra_pulse", 136'(rv_q.size()), 136'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
